// File: rtl/mem_arbiter_if.sv
// Request/grant and memory-side signals of the two-port memory arbiter.
// slave is the arbiter's view; master is the view of the requesters plus the memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
    output mem_read, mem_write, mem_addr, mem_data_in, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
    input  mem_read, mem_write, mem_addr, mem_data_in, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous 32x8 memory between two requesters.
// gnt+strobe one cycle after req is sampled in IDLE, rvalid one cycle later; requests are ignored until IDLE.
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, RESP = 2'd2} state_t;

  state_t            state, state_nxt;
  logic              last, last_nxt;
  logic              owner, owner_nxt;
  logic              win;
  logic [1:0]        gnt, gnt_nxt;
  logic [1:0]        rvalid, rvalid_nxt;
  logic              rd, rd_nxt;
  logic              wr, wr_nxt;
  logic              busy;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;

  // On a tie the requester that was not served last wins.
  always_comb begin
    win = 1'b0;
    if (bus.req0 && bus.req1) win = ~last;
    else if (bus.req1)        win = 1'b1;
  end

  always_comb begin
    state_nxt  = state;
    last_nxt   = last;
    owner_nxt  = owner;
    gnt_nxt    = 2'b00;
    rvalid_nxt = 2'b00;
    rd_nxt     = 1'b0;
    wr_nxt     = 1'b0;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_nxt    = CMD;
          last_nxt     = win;
          owner_nxt    = win;
          gnt_nxt[win] = 1'b1;
          if (win) begin
            addr_nxt  = bus.addr1;
            wdata_nxt = bus.wdata1;
            wr_nxt    = bus.we1;
            rd_nxt    = ~bus.we1;
          end else begin
            addr_nxt  = bus.addr0;
            wdata_nxt = bus.wdata0;
            wr_nxt    = bus.we0;
            rd_nxt    = ~bus.we0;
          end
        end
      end
      CMD: begin
        // Memory registers read data at the end of this cycle, so rvalid lines up with RESP.
        if (wr) begin
          state_nxt = IDLE;
        end else begin
          state_nxt         = RESP;
          rvalid_nxt[owner] = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      owner   <= 1'b0;
      gnt     <= 2'b00;
      rvalid  <= 2'b00;
      rd      <= 1'b0;
      wr      <= 1'b0;
      busy    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      owner   <= owner_nxt;
      gnt     <= gnt_nxt;
      rvalid  <= rvalid_nxt;
      rd      <= rd_nxt;
      wr      <= wr_nxt;
      busy    <= (state_nxt != IDLE);
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  assign bus.gnt0        = gnt[0];
  assign bus.gnt1        = gnt[1];
  assign bus.rvalid0     = rvalid[0];
  assign bus.rvalid1     = rvalid[1];
  assign bus.rdata       = bus.mem_data_out;
  assign bus.mem_read    = rd;
  assign bus.mem_write   = wr;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_data_in = wdata_q;
  assign bus.busy        = busy;
endmodule
